mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: requester channels, the single-port memory
// command/response pair, the output-window mirror and the protection flag.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [N_CH-1:0]        req;
  logic [N_CH-1:0]        we;
  logic [N_CH*ADDR_W-1:0] addr;
  logic [N_CH*DATA_W-1:0] wdata;
  logic                   hi_pri;
  logic [N_CH-1:0]        gnt;
  logic [N_CH-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_din;
  logic [DATA_W-1:0]      mem_dout;
  logic                   out_valid;
  logic [ADDR_W-1:0]      out_addr;
  logic [DATA_W-1:0]      out_data;
  logic                   wprot_err;

  modport slave (
    input  req, we, addr, wdata, hi_pri, mem_dout,
    output gnt, rvalid, rdata, mem_we, mem_addr, mem_din,
           out_valid, out_addr, out_data, wprot_err
  );

  modport master (
    output req, we, addr, wdata, hi_pri, mem_dout,
    input  gnt, rvalid, rdata, mem_we, mem_addr, mem_din,
           out_valid, out_addr, out_data, wprot_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: N_CH-channel round-robin arbiter in front of a single-port
// synchronous memory. Channel 0 can pre-empt rotation via hi_pri. Grants are
// combinational; the memory command is registered one cycle later and read
// data returns on rvalid two cycles after the grant. Writes into the output
// window are mirrored on out_*.
// Optional feature: define MEM_ARB_WPROT_EN to block writes into the
// read-only region (the write is granted but suppressed, wprot_err pulses).
module mem_arbiter #(
  parameter int N_CH     = 3,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int OUT_BASE = 19968,
  parameter int OUT_SIZE = 512,
  parameter int RO_BASE  = 8192,
  parameter int RO_SIZE  = 11264
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Window bounds are one bit wider than the address so a top of 2^ADDR_W
  // stays representable instead of wrapping to zero.
  localparam logic [ADDR_W:0] OUT_LO = (ADDR_W+1)'(OUT_BASE);
  localparam logic [ADDR_W:0] OUT_HI = (ADDR_W+1)'(OUT_BASE + OUT_SIZE);
  localparam logic [ADDR_W:0] RO_LO  = (ADDR_W+1)'(RO_BASE);
  localparam logic [ADDR_W:0] RO_HI  = (ADDR_W+1)'(RO_BASE + RO_SIZE);

`ifdef MEM_ARB_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  // Arbitration result for the current cycle
  logic [N_CH-1:0]   w_gnt;
  logic [CH_W-1:0]   w_sel;
  logic              w_any;

  // Granted channel's command
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [ADDR_W:0]   w_addr_x;
  logic              w_out_hit;
  logic              w_ro_hit;
  logic              w_ro_block;

  // Pipeline state
  logic [CH_W-1:0]   r_last_gnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic [N_CH-1:0]   r_rd_oh1;
  logic [N_CH-1:0]   r_rvalid;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  // Pick the winner: hi_pri channel 0 first, else rotate from last_gnt+1.
  always_comb begin
    logic [CH_W-1:0] j;
    // NOTE: every output gets a default before any branch, so no latch can
    // be inferred; blocking '=' is used because later statements read the
    // values written earlier in the same pass.
    w_gnt = '0;
    w_sel = '0;
    w_any = 1'b0;
    j     = '0;
    if (!reset) begin
      if (bus.hi_pri && bus.req[0]) begin
        w_gnt[0] = 1'b1;
        w_sel    = '0;
        w_any    = 1'b1;
      end else begin
        for (int k = 1; k <= N_CH; k++) begin
          j = CH_W'((int'(r_last_gnt) + k) % N_CH);
          if (!w_any && bus.req[j]) begin
            w_gnt[j] = 1'b1;
            w_sel    = j;
            w_any    = 1'b1;
          end
        end
      end
    end
  end

  // Mux the granted channel's command and classify its address.
  always_comb begin
    w_sel_we    = bus.we[w_sel];
    w_sel_addr  = bus.addr[w_sel*ADDR_W +: ADDR_W];
    w_sel_wdata = bus.wdata[w_sel*DATA_W +: DATA_W];
    w_addr_x    = {1'b0, w_sel_addr};
    w_out_hit   = (w_addr_x >= OUT_LO) && (w_addr_x < OUT_HI);
    w_ro_hit    = (w_addr_x >= RO_LO) && (w_addr_x < RO_HI);
  end

  assign w_ro_block = WPROT_EN & w_ro_hit & w_sel_we;

  // Register the memory command, read pipeline, mirror and rotation pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    if (reset) begin
      r_last_gnt  <= CH_W'(N_CH - 1);
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_rd_oh1    <= '0;
      r_rvalid    <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_any) begin
        r_last_gnt <= w_sel;
        r_mem_addr <= w_sel_addr;
        r_mem_din  <= w_sel_wdata;
      end
      r_mem_we    <= w_any & w_sel_we & ~w_ro_block;
      r_rd_oh1    <= (w_any && !w_sel_we) ? w_gnt : '0;
      r_rvalid    <= r_rd_oh1;
      r_out_valid <= w_any & w_sel_we & w_out_hit;
      if (w_any && w_sel_we && w_out_hit) begin
        r_out_addr <= w_sel_addr;
        r_out_data <= w_sel_wdata;
      end
    end
  end

`ifdef MEM_ARB_WPROT_EN
  logic r_wprot_err;

  // Flag a write that was granted but kept away from the read-only region.
  always_ff @(posedge clk) begin
    if (reset) r_wprot_err <= 1'b0;
    else       r_wprot_err <= w_any & w_ro_block;
  end

  assign bus.wprot_err = r_wprot_err & ~reset;
`else
  assign bus.wprot_err = 1'b0;
`endif

  // Outputs are forced low for the whole reset window, including the first
  // reset cycle before the synchronous clear has taken effect.
  assign bus.gnt       = w_gnt;
  assign bus.rvalid    = reset ? '0 : r_rvalid;
  assign bus.rdata     = (!reset && (|r_rvalid)) ? bus.mem_dout : '0;
  assign bus.mem_we    = r_mem_we & ~reset;
  assign bus.mem_addr  = reset ? '0 : r_mem_addr;
  assign bus.mem_din   = reset ? '0 : r_mem_din;
  assign bus.out_valid = r_out_valid & ~reset;
  assign bus.out_addr  = reset ? '0 : r_out_addr;
  assign bus.out_data  = reset ? '0 : r_out_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic. A driver computes expected grants and memory/read/mirror responses
// from the arbitration and address-window rules and queues them; a separate
// monitor compares them against the DUT outputs every cycle.
// Build with +define+MEM_ARB_WPROT_EN to exercise the write-protect variant.
module tb_mem_arbiter;

  localparam int N_CH     = 3;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int OUT_BASE = 19968;
  localparam int OUT_SIZE = 512;
  localparam int RO_BASE  = 8192;
  localparam int RO_SIZE  = 11264;
  localparam int MEM_WORDS = 2**ADDR_W;

`ifdef MEM_ARB_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef struct {
    int                cyc;
    int                ch;
    logic              we;
    logic              prot;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .OUT_BASE(OUT_BASE), .OUT_SIZE(OUT_SIZE),
    .RO_BASE(RO_BASE), .RO_SIZE(RO_SIZE)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t cmd_q[$];
  exp_t rd_q[$];
  exp_t out_q[$];

  logic [DATA_W-1:0] tb_mem  [MEM_WORDS];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];

  logic [N_CH-1:0]   d_req;
  logic [N_CH-1:0]   d_we;
  logic [ADDR_W-1:0] d_addr  [N_CH];
  logic [DATA_W-1:0] d_wdata [N_CH];
  logic              d_hi;
  int                m_last;
  int                g_obs;

  function automatic logic [DATA_W-1:0] init_word(int i);
    return DATA_W'(i * 37 + 5);
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Simple synchronous single-port memory, read-before-write.
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= tb_mem[bus.mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // One bench cycle: drive inputs after the edge, then at the falling edge
  // predict the grant and queue every response it implies.
  task automatic drive_cycle(input bit r);
    exp_t e;
    int   g;
    int   a;
    @(posedge clk);
    #1;
    rst = r;
    if (r) begin
      cmd_q.delete();
      rd_q.delete();
      out_q.delete();
      m_last = N_CH - 1;
    end
    bus.req    = d_req;
    bus.we     = d_we;
    bus.hi_pri = d_hi;
    for (int i = 0; i < N_CH; i++) begin
      bus.addr[i*ADDR_W +: ADDR_W]  = d_addr[i];
      bus.wdata[i*DATA_W +: DATA_W] = d_wdata[i];
    end
    @(negedge clk);
    g = -1;
    if (!r) begin
      if (d_hi && d_req[0]) g = 0;
      else
        for (int k = 1; k <= N_CH; k++)
          if (g < 0 && d_req[(m_last + k) % N_CH]) g = (m_last + k) % N_CH;
    end
    g_obs = g;
    check("gnt", 64'(bus.gnt), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      m_last = g;
      a      = int'(d_addr[g]);
      e.cyc  = cyc + 1;
      e.ch   = g;
      e.we   = d_we[g];
      e.addr = d_addr[g];
      e.data = d_wdata[g];
      e.prot = d_we[g] && WPROT && (a >= RO_BASE) && (a < RO_BASE + RO_SIZE);
      cmd_q.push_back(e);
      if (!d_we[g]) begin
        e.cyc  = cyc + 2;
        e.data = ref_mem[a];
        rd_q.push_back(e);
      end else begin
        if (!e.prot) ref_mem[a] = d_wdata[g];
        if (a >= OUT_BASE && a < OUT_BASE + OUT_SIZE) out_q.push_back(e);
      end
    end
  endtask

  // Monitor: pop whatever is due this cycle, otherwise expect silence.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("reset_ctl", 64'({bus.gnt, bus.rvalid, bus.mem_we, bus.out_valid, bus.wprot_err}), 64'd0);
      check("reset_data", 64'({bus.rdata, bus.mem_addr, bus.mem_din}), 64'd0);
      check("reset_out", 64'({bus.out_addr, bus.out_data}), 64'd0);
    end else begin
      if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
        e = cmd_q.pop_front();
        check("mem_we", 64'(bus.mem_we), 64'(e.we && !e.prot));
        check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
        if (e.we) check("mem_din", 64'(bus.mem_din), 64'(e.data));
        check("wprot_err", 64'(bus.wprot_err), 64'(e.prot));
      end else begin
        check("mem_we_idle", 64'(bus.mem_we), 64'd0);
        check("wprot_idle", 64'(bus.wprot_err), 64'd0);
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        e = rd_q.pop_front();
        check("rvalid", 64'(bus.rvalid), 64'd1 << e.ch);
        check("rdata", 64'(bus.rdata), 64'(e.data));
      end else begin
        check("rvalid_idle", 64'(bus.rvalid), 64'd0);
      end
      if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
        e = out_q.pop_front();
        check("out_valid", 64'(bus.out_valid), 64'd1);
        check("out_addr", 64'(bus.out_addr), 64'(e.addr));
        check("out_data", 64'(bus.out_data), 64'(e.data));
      end else begin
        check("out_idle", 64'(bus.out_valid), 64'd0);
      end
    end
  end

  function automatic logic [ADDR_W-1:0] pick_addr();
    int a;
    case ($urandom_range(5))
      0:       a = int'($urandom_range(MEM_WORDS - 1));
      1:       a = OUT_BASE - 1 + int'($urandom_range(2));
      2:       a = OUT_BASE + OUT_SIZE - 1 + int'($urandom_range(1));
      3:       a = RO_BASE - 1 + int'($urandom_range(2));
      4:       a = RO_BASE + RO_SIZE - 1 + int'($urandom_range(1));
      default: a = 16 + int'($urandom_range(7));
    endcase
    return ADDR_W'(a);
  endfunction

  task automatic set_chan(int c, logic w, int a, logic [DATA_W-1:0] dat);
    d_we[c]    = w;
    d_addr[c]  = ADDR_W'(a);
    d_wdata[c] = dat;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N_CH-1:0] pend;
    int diffs;

    for (int i = 0; i < MEM_WORDS; i++) begin
      tb_mem[i]  = init_word(i);
      ref_mem[i] = init_word(i);
    end
    d_req = '0;
    d_we  = '0;
    d_hi  = 1'b0;
    for (int i = 0; i < N_CH; i++) set_chan(i, 1'b0, 0, '0);
    bus.req = '0; bus.we = '0; bus.hi_pri = 1'b0; bus.addr = '0; bus.wdata = '0;
    m_last = N_CH - 1;

    // Reset held with all channels requesting: nothing may be granted.
    d_req = 3'b111;
    repeat (3) drive_cycle(1'b1);

    // Round-robin from channel 0 after reset, all reads.
    for (int i = 0; i < N_CH; i++) set_chan(i, 1'b0, 100 + i, '0);
    drive_cycle(1'b0); check("rr_0", 64'(bus.gnt), 64'b001);
    drive_cycle(1'b0); check("rr_1", 64'(bus.gnt), 64'b010);
    drive_cycle(1'b0); check("rr_2", 64'(bus.gnt), 64'b100);
    drive_cycle(1'b0); check("rr_3", 64'(bus.gnt), 64'b001);

    // hi_pri pins channel 0, then rotation resumes after it.
    d_req = 3'b011;
    d_hi  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0);
      check("hipri", 64'(bus.gnt), 64'b001);
    end
    d_hi = 1'b0;
    drive_cycle(1'b0); check("hipri_release", 64'(bus.gnt), 64'b010);

    // Output window: first word, one past top, one below base, last word.
    d_req = 3'b010;
    set_chan(1, 1'b1, 19968, 16'hBEEF);
    drive_cycle(1'b0);
    d_req = '0;
    drive_cycle(1'b0);
    check("win_base_valid", 64'(bus.out_valid), 64'd1);
    check("win_base_addr", 64'(bus.out_addr), 64'd19968);
    check("win_base_data", 64'(bus.out_data), 64'hBEEF);
    d_req = 3'b010;
    set_chan(1, 1'b1, 20480, 16'hBEEF);
    drive_cycle(1'b0);
    d_req = '0;
    drive_cycle(1'b0);
    check("win_top_excl", 64'(bus.out_valid), 64'd0);
    d_req = 3'b010;
    set_chan(1, 1'b1, 19967, 16'h5A5A);
    drive_cycle(1'b0);
    d_req = '0;
    drive_cycle(1'b0);
    check("win_below", 64'(bus.out_valid), 64'd0);
    d_req = 3'b010;
    set_chan(1, 1'b1, 20479, 16'hA5A5);
    drive_cycle(1'b0);
    d_req = '0;
    drive_cycle(1'b0);
    check("win_last_valid", 64'(bus.out_valid), 64'd1);
    check("win_last_addr", 64'(bus.out_addr), 64'd20479);

    // Write into the read-only region from channel 2.
    d_req = 3'b100;
    set_chan(2, 1'b1, 8192, 16'h1234);
    drive_cycle(1'b0);
    check("ro_gnt", 64'(bus.gnt), 64'b100);
    d_req = '0;
    drive_cycle(1'b0);
    check("ro_mem_we", 64'(bus.mem_we), WPROT ? 64'd0 : 64'd1);
    check("ro_wprot", 64'(bus.wprot_err), WPROT ? 64'd1 : 64'd0);
    drive_cycle(1'b0);
    check("ro_mem_word", 64'(tb_mem[8192]), WPROT ? 64'(init_word(8192)) : 64'h1234);

    // Read in flight across a one-cycle reset is dropped.
    d_req = 3'b010;
    set_chan(1, 1'b0, 300, '0);
    drive_cycle(1'b0);
    check("flush_gnt", 64'(bus.gnt), 64'b010);
    d_req = '0;
    drive_cycle(1'b1);
    drive_cycle(1'b0);
    check("flush_no_rvalid", 64'(bus.rvalid), 64'd0);
    d_req = 3'b111;
    for (int i = 0; i < N_CH; i++) set_chan(i, 1'b0, 200 + i, '0);
    drive_cycle(1'b0);
    check("flush_next_ch0", 64'(bus.gnt), 64'b001);
    d_req = '0;
    repeat (3) drive_cycle(1'b0);

    // Random traffic: requests held until granted, occasionally withdrawn.
    pend = '0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (pend[c] && $urandom_range(15) == 0) pend[c] = 1'b0;
        else if (!pend[c] && $urandom_range(1) == 1) begin
          pend[c] = 1'b1;
          set_chan(c, 1'($urandom_range(1)), int'(pick_addr()), DATA_W'($urandom));
        end
      end
      d_req = pend;
      d_hi  = ($urandom_range(3) == 0);
      drive_cycle(1'b0);
      if (g_obs >= 0) pend[g_obs] = 1'b0;
    end

    d_req = '0;
    d_hi  = 1'b0;
    repeat (4) drive_cycle(1'b0);
    check("drain", 64'(cmd_q.size() + rd_q.size() + out_q.size()), 64'd0);
    diffs = 0;
    for (int i = 0; i < MEM_WORDS; i++)
      if (tb_mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", 64'(diffs), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
